// File: rtl/mem_port_arbiter_if.sv
// Instruction port, data port and single-port SRAM bus around mem_port_arbiter.
// slave is the arbiter's view; master is the CPU/SRAM side.
interface mem_port_arbiter_if;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_ack;
   logic [31:0] inst_rdata;

   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_ack;
   logic [31:0] data_rdata;

   logic        ram_en;
   logic        ram_we;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   modport slave (
      input  inst_req, inst_addr,
      input  data_req, data_wr, data_size, data_addr, data_wdata,
      input  ram_rdata,
      output inst_ack, inst_rdata, data_ack, data_rdata,
      output ram_en, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output inst_req, inst_addr,
      output data_req, data_wr, data_size, data_addr, data_wdata,
      output ram_rdata,
      input  inst_ack, inst_rdata, data_ack, data_rdata,
      input  ram_en, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch and load/store traffic.
// Sub-word stores use read-modify-write; instruction fetch is starved at most STARVE_MAX grants.
module mem_port_arbiter #(
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave bus
);

   localparam int               CNT_W      = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   typedef enum logic [1:0] {IDLE, RD_ACK, WR_ACK, RMW} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] starve_cnt, starve_nxt;
   logic             ack_inst, ack_inst_nxt;  // RD_ACK answers the fetch port when set
   logic             grant_data, grant_inst, store_word;
   logic [31:0]      data_word_addr, inst_word_addr;

   assign grant_data     = bus.data_req && (!bus.inst_req || (starve_cnt < STARVE_LIM));
   assign grant_inst     = bus.inst_req && !grant_data;
   assign store_word     = bus.data_wr && bus.data_size[1];
   assign data_word_addr = {bus.data_addr[31:2], 2'b00};
   assign inst_word_addr = {bus.inst_addr[31:2], 2'b00};

   function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane);
      logic [31:0] word;
      word = old_word;
      if (size == 2'b00) begin
         case (lane)
            2'd0:    word[7:0]   = wdata[7:0];
            2'd1:    word[15:8]  = wdata[7:0];
            2'd2:    word[23:16] = wdata[7:0];
            default: word[31:24] = wdata[7:0];
         endcase
      end else if (lane[1]) begin
         word[31:16] = wdata[15:0];
      end else begin
         word[15:0] = wdata[15:0];
      end
      return word;
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         starve_cnt <= '0;
         ack_inst   <= 1'b0;
      end else begin
         state      <= state_nxt;
         starve_cnt <= starve_nxt;
         ack_inst   <= ack_inst_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      starve_nxt   = starve_cnt;
      ack_inst_nxt = ack_inst;
      case (state)
         IDLE: begin
            if (grant_data) begin
               ack_inst_nxt = 1'b0;
               if (!bus.inst_req)
                  starve_nxt = '0;
               else if (starve_cnt != STARVE_LIM)
                  starve_nxt = starve_cnt + 1'b1;
               if (!bus.data_wr)
                  state_nxt = RD_ACK;
               else if (store_word)
                  state_nxt = WR_ACK;
               else
                  state_nxt = RMW;
            end else if (grant_inst) begin
               ack_inst_nxt = 1'b1;
               starve_nxt   = '0;
               state_nxt    = RD_ACK;
            end
         end
         RMW:     state_nxt = WR_ACK;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: every output gets a default first so no path through the case infers a latch.
   always_comb begin
      bus.inst_ack   = 1'b0;
      bus.inst_rdata = '0;
      bus.data_ack   = 1'b0;
      bus.data_rdata = '0;
      bus.ram_en     = 1'b0;
      bus.ram_we     = 1'b0;
      bus.ram_addr   = '0;
      bus.ram_wdata  = '0;
      if (!reset) begin
         case (state)
            IDLE: begin
               if (grant_data) begin
                  bus.ram_en   = 1'b1;
                  bus.ram_addr = data_word_addr;
                  if (store_word) begin
                     bus.ram_we    = 1'b1;
                     bus.ram_wdata = bus.data_wdata;
                  end
               end else if (grant_inst) begin
                  bus.ram_en   = 1'b1;
                  bus.ram_addr = inst_word_addr;
               end
            end
            RD_ACK: begin
               if (ack_inst) begin
                  bus.inst_ack   = 1'b1;
                  bus.inst_rdata = bus.ram_rdata;
               end else begin
                  bus.data_ack   = 1'b1;
                  bus.data_rdata = bus.ram_rdata;
               end
            end
            RMW: begin
               // ram_rdata holds the word read in the grant cycle
               bus.ram_en    = 1'b1;
               bus.ram_we    = 1'b1;
               bus.ram_addr  = data_word_addr;
               bus.ram_wdata = merge_store(bus.ram_rdata, bus.data_wdata,
                                           bus.data_size, bus.data_addr[1:0]);
            end
            default: bus.data_ack = 1'b1;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter against a transaction-level model
// that predicts each bus cycle and tracks the expected SRAM contents.
module tb_mem_port_arbiter;

   localparam int          STARVE_MAX = 4;
   localparam logic [31:0] BASE       = 32'h1c00_0000;

   logic clk = 1'b0;
   logic reset;
   logic ram_init;
   logic hold_inst, hold_data;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc      = 0;

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- SRAM emulation (written only by the DUT) ----------------
   logic [31:0] mem [256];

   function automatic logic [31:0] seed_word(input int i);
      return (32'h9e37_79b9 * 32'(i)) ^ 32'h5a5a_0f0f;
   endfunction

   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= seed_word(i);
      end else if (bus.ram_en && bus.ram_we) begin
         mem[bus.ram_addr[9:2]] <= bus.ram_wdata;
      end
      if (bus.ram_en && !bus.ram_we) bus.ram_rdata <= mem[bus.ram_addr[9:2]];
      else                           bus.ram_rdata <= $urandom;
   end

   // ---------------- reference model ----------------
   typedef struct {
      logic        en, we;
      logic [31:0] addr, wdata;
      logic        iack, dack, chk_drd;
      logic [31:0] irdata, drdata;
      logic        commit;
      logic [7:0]  widx;
      logic [31:0] wword;
   } exp_t;

   typedef struct {
      logic        inst_ack, data_ack, ram_en, ram_we;
      logic [31:0] inst_rdata, data_rdata, ram_addr, ram_wdata;
   } obs_t;

   exp_t        q[$];
   obs_t        obs;
   logic [31:0] ref_mem [256];
   int          starve;

   function automatic logic [31:0] ref_merge(input logic [31:0] old_word, input logic [31:0] wd,
                                             input logic is_half, input logic [1:0] lo2);
      logic [31:0] mask;
      int          sh;
      if (is_half) begin
         sh   = lo2[1] ? 16 : 0;
         mask = 32'h0000_ffff << sh;
      end else begin
         sh   = 8 * int'(lo2);
         mask = 32'h0000_00ff << sh;
      end
      return (old_word & ~mask) | ((wd << sh) & mask);
   endfunction

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_errors++;
         $error("FAIL %s @cycle %0d: observed %h expected %h", tag, cyc, observed, expected);
      end
   endtask

   task automatic arbitrate(output exp_t e);
      exp_t        a, b;
      logic [7:0]  idx;
      e = '{default: '0};
      a = '{default: '0};
      b = '{default: '0};
      if (bus.data_req && (!bus.inst_req || starve < STARVE_MAX)) begin
         idx    = bus.data_addr[9:2];
         starve = bus.inst_req ? ((starve < STARVE_MAX) ? starve + 1 : starve) : 0;
         e.en   = 1'b1;
         e.addr = {bus.data_addr[31:2], 2'b00};
         if (!bus.data_wr) begin
            a.dack = 1'b1; a.chk_drd = 1'b1; a.drdata = ref_mem[idx];
            q.push_back(a);
         end else if (bus.data_size[1]) begin
            e.we = 1'b1; e.wdata = bus.data_wdata;
            e.commit = 1'b1; e.widx = idx; e.wword = bus.data_wdata;
            a.dack = 1'b1;
            q.push_back(a);
         end else begin
            a.en = 1'b1; a.we = 1'b1; a.addr = e.addr;
            a.wdata = ref_merge(ref_mem[idx], bus.data_wdata, bus.data_size[0], bus.data_addr[1:0]);
            a.commit = 1'b1; a.widx = idx; a.wword = a.wdata;
            b.dack = 1'b1;
            q.push_back(a);
            q.push_back(b);
         end
      end else if (bus.inst_req) begin
         starve = 0;
         e.en   = 1'b1;
         e.addr = {bus.inst_addr[31:2], 2'b00};
         a.iack = 1'b1; a.irdata = ref_mem[bus.inst_addr[9:2]];
         q.push_back(a);
      end
   endtask

   // Samples one bus cycle mid-period, checks it against the model, then moves past the edge.
   task automatic cycle();
      exp_t e;
      e = '{default: '0};
      @(negedge clk);
      obs.inst_ack   = bus.inst_ack;   obs.inst_rdata = bus.inst_rdata;
      obs.data_ack   = bus.data_ack;   obs.data_rdata = bus.data_rdata;
      obs.ram_en     = bus.ram_en;     obs.ram_we     = bus.ram_we;
      obs.ram_addr   = bus.ram_addr;   obs.ram_wdata  = bus.ram_wdata;
      if (reset) begin
         q.delete();
         starve = 0;
      end else if (q.size() != 0) begin
         e = q.pop_front();
      end else begin
         arbitrate(e);
      end
      check("ram_en", obs.ram_en, e.en);
      check("ram_we", obs.ram_we, e.we);
      if (e.en) check("ram_addr", obs.ram_addr, e.addr);
      check("ram_wdata", obs.ram_wdata, e.wdata);
      check("inst_ack", obs.inst_ack, e.iack);
      check("inst_rdata", obs.inst_rdata, e.irdata);
      check("data_ack", obs.data_ack, e.dack);
      if (!e.dack || e.chk_drd) check("data_rdata", obs.data_rdata, e.drdata);
      if (e.commit) ref_mem[e.widx] = e.wword;
      cyc++;
      @(posedge clk);
      #1;
      if (e.iack && !hold_inst) bus.inst_req = 1'b0;
      if (e.dack && !hold_data) bus.data_req = 1'b0;
   endtask

   task automatic data_op(input logic wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata);
      bus.data_req   = 1'b1;
      bus.data_wr    = wr;
      bus.data_size  = size;
      bus.data_addr  = addr;
      bus.data_wdata = wdata;
   endtask

   function automatic logic [31:0] rand_addr();
      return BASE | (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3));
   endfunction

   // ---------------- stimulus ----------------
   initial begin : main
      int n_before, n_between, n_inst;
      reset = 1'b1; ram_init = 1'b1; hold_inst = 1'b0; hold_data = 1'b0; starve = 0;
      bus.inst_req = 1'b0; bus.inst_addr = '0;
      bus.data_req = 1'b0; bus.data_wr = 1'b0; bus.data_size = 2'b00;
      bus.data_addr = '0; bus.data_wdata = '0;
      for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);

      // reset: a request during reset is ignored, outputs idle afterwards
      cycle();
      ram_init = 1'b0;
      bus.inst_req = 1'b1; bus.inst_addr = BASE + 32'h4;
      cycle();
      check("reset_blocks_ram_en", obs.ram_en, 1'b0);
      check("reset_blocks_inst_ack", obs.inst_ack, 1'b0);
      reset = 1'b0; bus.inst_req = 1'b0;
      cycle();
      check("post_reset_flags", {28'd0, obs.inst_ack, obs.data_ack, obs.ram_en, obs.ram_we}, 32'd0);
      check("post_reset_ram_addr", obs.ram_addr, 32'd0);

      // inst read of a freshly stored word
      data_op(1'b1, 2'b10, BASE + 32'h4, 32'h0280_0c0c);
      cycle(); cycle();
      bus.inst_req = 1'b1; bus.inst_addr = 32'h1c00_0004;
      cycle();
      check("iread_c0_ram_en", obs.ram_en, 1'b1);
      check("iread_c0_ram_addr", obs.ram_addr, 32'h1c00_0004);
      cycle();
      check("iread_c1_inst_ack", obs.inst_ack, 1'b1);
      check("iread_c1_inst_rdata", obs.inst_rdata, 32'h0280_0c0c);

      // simultaneous fetch and load: data first, then fetch
      data_op(1'b0, 2'b10, BASE + 32'h4, 32'h0);
      bus.inst_req = 1'b1; bus.inst_addr = BASE;
      cycle();
      check("both_c0_data_addr", obs.ram_addr, 32'h1c00_0004);
      cycle();
      check("both_c1_data_ack", obs.data_ack, 1'b1);
      check("both_c1_data_rdata", obs.data_rdata, 32'h0280_0c0c);
      check("both_c1_no_inst_ack", obs.inst_ack, 1'b0);
      cycle();
      check("both_c2_inst_addr", {obs.ram_en, obs.ram_addr[30:0]}, {1'b1, 31'h1c00_0000});
      cycle();
      check("both_c3_inst_ack", obs.inst_ack, 1'b1);

      // byte store read-modify-write
      data_op(1'b1, 2'b10, 32'h1c00_8000, 32'h1122_3344);
      cycle(); cycle();
      data_op(1'b1, 2'b00, 32'h1c00_8003, 32'h0000_00ab);
      cycle();
      check("stb_c0_read", {obs.ram_en, obs.ram_we}, 32'd2);
      check("stb_c0_addr", obs.ram_addr, 32'h1c00_8000);
      cycle();
      check("stb_c1_we", obs.ram_we, 1'b1);
      check("stb_c1_wdata", obs.ram_wdata, 32'hab22_3344);
      cycle();
      check("stb_c2_data_ack", obs.data_ack, 1'b1);

      // half store into upper lane
      data_op(1'b1, 2'b10, 32'h1c00_8000, 32'h1122_3344);
      cycle(); cycle();
      data_op(1'b1, 2'b01, 32'h1c00_8002, 32'h0000_beef);
      cycle();
      cycle();
      check("sth_c1_wdata", obs.ram_wdata, 32'hbeef_3344);
      cycle();
      check("sth_c2_data_ack", obs.data_ack, 1'b1);

      // reset during RMW abandons the store
      data_op(1'b1, 2'b00, 32'h1c00_8001, 32'h0000_0055);
      cycle();
      reset = 1'b1;
      cycle();
      check("rst_rmw_we", obs.ram_we, 1'b0);
      check("rst_rmw_no_ack", obs.data_ack, 1'b0);
      reset = 1'b0; bus.data_req = 1'b0;
      cycle();
      check("rst_rmw_idle", {obs.ram_en, obs.data_ack}, 32'd0);
      check("rst_rmw_mem_unchanged", mem[0], 32'hbeef_3344);

      // starvation bound with both requests held high
      n_before = 0; n_between = 0; n_inst = 0;
      hold_inst = 1'b1; hold_data = 1'b1;
      data_op(1'b0, 2'b10, BASE + 32'h4, 32'h0);
      bus.inst_req = 1'b1; bus.inst_addr = BASE + 32'h8;
      for (int t = 0; t < 40 && n_inst < 2; t++) begin
         cycle();
         if (obs.data_ack) begin
            if (n_inst == 0) n_before++;
            else             n_between++;
         end
         if (obs.inst_ack) n_inst++;
      end
      hold_inst = 1'b0; hold_data = 1'b0;
      bus.inst_req = 1'b0; bus.data_req = 1'b0;
      check("starve_data_before_inst", n_before, STARVE_MAX);
      check("starve_data_after_clear", n_between, STARVE_MAX);
      check("starve_inst_grants", n_inst, 2);

      // randomized traffic with occasional reset
      for (int t = 0; t < 3000; t++) begin
         if (!bus.inst_req && $urandom_range(0, 2) == 0) begin
            bus.inst_req  = 1'b1;
            bus.inst_addr = rand_addr();
         end
         if (!bus.data_req && $urandom_range(0, 1) == 0)
            data_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rand_addr(), $urandom);
         reset = !reset && ($urandom_range(0, 149) == 0);
         cycle();
      end
      reset = 1'b0;
      for (int t = 0; t < 20 && (bus.inst_req || bus.data_req); t++) cycle();
      cycle();
      cycle();
      for (int i = 0; i < 256; i++) check("mem_word", mem[i], ref_mem[i]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_MAX, default 4: max consecutive data grants while inst_req is pending.
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port inst_req  input  1  fetch request, held until inst_ack.
REQ-005 SHALL have port inst_addr  input  32  fetch byte address, stable while inst_req is high.
REQ-006 SHALL have port inst_ack  output  1  one-cycle fetch completion pulse.
REQ-007 SHALL have port inst_rdata  output  32  fetched word, valid only with inst_ack.
REQ-008 SHALL have port data_req  input  1  load/store request, held until data_ack.
REQ-009 SHALL have port data_wr  input  1  1 = store, 0 = load.
REQ-010 SHALL have port data_size  input  2  00 byte, 01 half, 10/11 word.
REQ-011 SHALL have port data_addr  input  32  byte address, stable while data_req is high.
REQ-012 SHALL have port data_wdata  input  32  store data, right-aligned: byte in [7:0], half in [15:0].
REQ-013 SHALL have port data_ack  output  1  one-cycle load/store completion pulse.
REQ-014 SHALL have port data_rdata  output  32  raw aligned RAM word, valid only with data_ack.
REQ-015 SHALL have port ram_en  output  1  single-port SRAM access strobe.
REQ-016 SHALL have port ram_we  output  1  word write enable, qualified by ram_en.
REQ-017 SHALL have port ram_addr  output  32  word address {addr[31:2],2'b00}.
REQ-018 SHALL have port ram_wdata  output  32  full write word.
REQ-019 SHALL have port ram_rdata  input  32  read data, valid the cycle after ram_en with ram_we=0.

Function
REQ-020 SHALL implement states IDLE, RD_ACK, WR_ACK, RMW.
REQ-021 In IDLE, a data grant SHALL occur if data_req=1 and (inst_req=0 or starve_cnt<STARVE_MAX); otherwise an inst grant SHALL occur if inst_req=1.
REQ-022 SHALL drive ram_en, ram_we and ram_addr combinationally in the grant cycle from the granted request.
REQ-023 Inst grant or data load: ram_en=1, ram_we=0, then RD_ACK; RD_ACK SHALL pulse the matching ack with rdata=ram_rdata, then return to IDLE (2-cycle latency).
REQ-024 Word store: ram_en=1, ram_we=1, ram_wdata=data_wdata, then WR_ACK; WR_ACK SHALL pulse data_ack, then go to IDLE (2 cycles).
REQ-025 Byte/half store: the grant cycle SHALL issue a read, then RMW; RMW SHALL write the merged word with ram_en=1, ram_we=1, then WR_ACK (3 cycles).
REQ-026 Byte merge SHALL replace lane addr[1:0] (bits 8*k+7:8*k) with data_wdata[7:0]; the other lanes SHALL keep ram_rdata.
REQ-027 Half merge SHALL replace [31:16] if addr[1]=1, else [15:0], with data_wdata[15:0]; addr[0] SHALL be ignored.
REQ-028 For word accesses, addr[1:0] SHALL be ignored.
REQ-029 starve_cnt SHALL increment (saturating at STARVE_MAX) on each data grant with inst_req=1.
REQ-030 starve_cnt SHALL clear on any inst grant and on a data grant with inst_req=0.
REQ-031 Only one transaction SHALL be in flight; requests SHALL be sampled only in IDLE.
REQ-032 A request still high in the cycle after its ack SHALL be treated as a new request.
REQ-033 inst_rdata and data_rdata SHALL be 0 when their ack is low.
REQ-034 ram_wdata SHALL be 0 whenever ram_we=0.
REQ-035 IDLE with no request SHALL keep ram_en=0.

Reset
REQ-036 While reset=1, ram_en, ram_we, inst_ack and data_ack SHALL be forced 0 in the same cycle, regardless of state.
REQ-037 Reset SHALL set state to IDLE and starve_cnt to 0; all outputs SHALL be 0 in the first cycle after reset.
REQ-038 A transaction interrupted by reset SHALL be abandoned with no ack and no partial write.

Verification
REQ-039 Inst read: inst_req, addr 0x1c000004, ram returns 0x02800c0c -> cycle0 ram_en=1, ram_addr=0x1c000004; cycle1 inst_ack=1, inst_rdata=0x02800c0c.
REQ-040 Simultaneous inst_req and data load with starve_cnt=0 -> data granted cycle0 and acked cycle1; inst granted cycle2 and acked cycle3.
REQ-041 st.b: addr 0x1c008003, wdata 0x000000AB, RAM word 0x11223344 -> cycle0 read; cycle1 write 0xAB223344; cycle2 data_ack.
REQ-042 st.h: addr 0x1c008002, wdata 0x0000BEEF, RAM word 0x11223344 -> write 0xBEEF3344; data_ack on the third cycle.
REQ-043 Starvation, STARVE_MAX=4: data_req and inst_req held high -> exactly 4 data grants, then an inst grant, then starve_cnt=0.
REQ-044 Reset asserted in the RMW cycle -> ram_we=0 that cycle, no data_ack, IDLE next cycle, and the RAM word is unchanged.
